// File: rtl/win23_if.sv
// Row-stream bundle for the Winograd F(2x2,3x3) input transform: tile rows in, V rows out.
`timescale 1ns/1ps
interface win23_if #(
    parameter int unsigned DW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_row;
    logic            out_valid;
    logic            out_ready;
    logic [4*DW-1:0] out_row;
    logic            out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_last
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_last
    );
endinterface

// File: rtl/win23_in_xform.sv
// Winograd F(2x2,3x3) input transform V = B^T*d*B: buffers a 4x4 tile, then streams the four V rows.
`timescale 1ns/1ps
module win23_in_xform #(
    parameter int unsigned DW = 16
) (
    input logic   clk,
    input logic   rst,
    win23_if.slave bus
);
    typedef enum logic {StFill, StDrain} state_e;

    state_e          state_q, state_d;
    logic [1:0]      fill_cnt_q, fill_cnt_d;
    logic [1:0]      drain_cnt_q, drain_cnt_d;
    logic [4*DW-1:0] buf_q [4];

    logic            accept;
    logic [DW-1:0]   d [4][4];
    logic [DW-1:0]   t [4];
    logic [4*DW-1:0] v_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            if (accept) begin
                buf_q[fill_cnt_q] <= bus.in_row;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        bus.in_ready  = (state_q == StFill);
        bus.out_valid = (state_q == StDrain);
        accept        = bus.in_valid & bus.in_ready;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    fill_cnt_d = fill_cnt_q + 2'd1;
                    if (fill_cnt_q == 2'd3) begin
                        state_d     = StDrain;
                        drain_cnt_d = '0;
                    end
                end
            end
            StDrain: begin
                if (bus.out_ready) begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                    if (drain_cnt_q == 2'd3) begin
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
        bus.out_last = bus.out_valid & (drain_cnt_q == 2'd3);
    end

    // Only the row stage for the V row currently presented is evaluated; results wrap mod 2^DW.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                d[r][c] = buf_q[r][(4-c)*DW-1 -: DW];
            end
        end
        for (int c = 0; c < 4; c++) begin
            unique case (drain_cnt_q)
                2'd0: t[c] = d[0][c] - d[2][c];
                2'd1: t[c] = d[1][c] + d[2][c];
                2'd2: t[c] = d[2][c] - d[1][c];
                2'd3: t[c] = d[1][c] - d[3][c];
            endcase
        end
        v_row       = {t[0] - t[2], t[1] + t[2], t[2] - t[1], t[1] - t[3]};
        bus.out_row = (state_q == StDrain) ? v_row : '0;
    end
endmodule

// File: tb/tb_win23_in_xform.sv
// Self-checking bench for win23_in_xform: directed tiles, backpressure, reset, randomized traffic.
`timescale 1ns/1ps
module tb_win23_in_xform;
    typedef logic [63:0] tile_t [4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    win23_if #(.DW(16)) bus ();

    win23_in_xform #(.DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full matrix product B^T * d * B in integers, reduced mod 2^16 at the end.
    task automatic model(input tile_t din, output tile_t vout);
        int bt [4][4];
        int dm [4][4];
        int tm [4][4];
        int acc;
        logic [15:0] e;
        bt = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                e = din[i][63-16*j -: 16];
                dm[i][j] = int'($signed(e));
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                tm[k][j] = 0;
                for (int m = 0; m < 4; m++) tm[k][j] += bt[k][m] * dm[m][j];
            end
        end
        vout = '{default: 64'h0};
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int m = 0; m < 4; m++) acc += tm[k][m] * bt[j][m];
                vout[k][63-16*j -: 16] = acc[15:0];
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_out_row", bus.out_row, 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic fill_rows(input tile_t rows, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_row    = rows[i];
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("fill_in_ready", 64'(bus.in_ready), 64'(1));
        end
    endtask

    // Streams one tile with random gaps and checks every output handshake against exp.
    task automatic run_tile(input tile_t rows, input tile_t exp, input int pv, input int pr);
        int fi = 0;
        int di = 0;
        int cyc = 0;
        bit chk_lat = 1'b0;
        while (di < 4) begin
            @(negedge clk);
            if (cyc++ > 300) begin
                check("tile_timeout", 64'(di), 64'(4));
                bus.in_valid = 1'b0;
                return;
            end
            if (fi < 4) begin
                bus.in_valid = ($urandom_range(1, 100) <= pv);
                bus.in_row   = rows[fi];
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_row   = {$urandom, $urandom};
            end
            bus.out_ready = ($urandom_range(1, 100) <= pr);
            #1;
            check("in_ready_vs_valid", 64'(bus.in_ready), 64'(!bus.out_valid));
            check("spurious_out", 64'(bus.out_valid && fi < 4), 64'(0));
            check("extra_accept", 64'(bus.in_valid && bus.in_ready && fi == 4), 64'(0));
            if (chk_lat) begin
                check("first_row_latency", 64'(bus.out_valid), 64'(1));
                chk_lat = 1'b0;
            end
            if (bus.out_valid) check("out_last", 64'(bus.out_last), 64'(di == 3));
            if (bus.in_valid && bus.in_ready && fi < 4) begin
                fi++;
                if (fi == 4) chk_lat = 1'b1;
            end
            if (bus.out_valid && bus.out_ready && fi == 4) begin
                check($sformatf("v_row%0d", di), bus.out_row, exp[di]);
                di++;
            end
        end
    endtask

    tile_t rows, exp, junk;
    logic [63:0] hold_row;
    logic [15:0] el;
    logic [15:0] corners [4];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;
        corners = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
        do_reset();

        // Directed tiles
        rows = '{64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001,
                 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001};
        exp  = '{64'h0, 64'h0000_0004_0000_0000, 64'h0, 64'h0};
        run_tile(rows, exp, 100, 100);
        rows = '{64'h0001_0000_0000_0000, 64'h0, 64'h0, 64'h0};
        exp  = '{64'h0001_0000_0000_0000, 64'h0, 64'h0, 64'h0};
        run_tile(rows, exp, 100, 100);
        rows = '{64'h0, 64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h0};
        exp  = '{64'hFFFF_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h8002_0000_0000_0000, 64'h7FFF_0000_0000_0000};
        run_tile(rows, exp, 100, 100);

        // Backpressure, including a stall while out_last is high
        for (int i = 0; i < 4; i++) rows[i] = {$urandom, $urandom};
        model(rows, exp);
        fill_rows(rows, 4);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        hold_row = bus.out_row;
        check("bp_first_row", hold_row, exp[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_row   = {$urandom, $urandom};
            #1;
            check("bp_row_stable", bus.out_row, hold_row);
            check("bp_last_low", 64'(bus.out_last), 64'(0));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            check("bp_drain_valid", 64'(bus.out_valid), 64'(1));
            check($sformatf("bp_row%0d", k), bus.out_row, exp[k]);
            check("bp_drain_last", 64'(bus.out_last), 64'(k == 3));
            if (k == 3) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    #1;
                    check("bp_last_stable", 64'(bus.out_last), 64'(1));
                    check("bp_row4_stable", bus.out_row, exp[3]);
                end
                bus.out_ready = 1'b1;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("bp_back_to_fill", 64'(bus.out_valid), 64'(0));
        check("bp_ready_again", 64'(bus.in_ready), 64'(1));

        // Reset after two accepted rows discards the partial tile
        for (int i = 0; i < 4; i++) junk[i] = {$urandom, $urandom};
        fill_rows(junk, 2);
        do_reset();
        for (int i = 0; i < 4; i++) rows[i] = {$urandom, $urandom};
        model(rows, exp);
        run_tile(rows, exp, 70, 70);

        // Reset in DRAIN after two V rows
        fill_rows(junk, 4);
        model(junk, exp);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("rd_row%0d", k), bus.out_row, exp[k]);
        end
        do_reset();
        for (int i = 0; i < 4; i++) rows[i] = {$urandom, $urandom};
        model(rows, exp);
        run_tile(rows, exp, 100, 100);

        // Randomized traffic with corner-value elements mixed in
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    el = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)]
                                                     : 16'($urandom);
                    rows[i][63-16*j -: 16] = el;
                end
            end
            model(rows, exp);
            run_tile(rows, exp, $urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
